// File: rtl/ascii_inst_pkg.sv
// Shared ASCII character constants for the UART text protocols.
package ascii_inst_pkg;
  localparam logic [7:0] _OPEN_BRACE   = 8'h7B;
  localparam logic [7:0] _CLOSE_BRACE  = 8'h7D;
  localparam logic [7:0] _DOUBLE_QUOTE = 8'h22;
  localparam logic [7:0] _COLON        = 8'h3A;
  localparam logic [7:0] _COMMA        = 8'h2C;
  localparam logic [7:0] _PERIOD       = 8'h2E;
  localparam logic [7:0] _MINUS        = 8'h2D;
  localparam logic [7:0] _LINE_FEED    = 8'h0A;
  localparam logic [7:0] _DIGIT_0      = 8'h30;
  localparam logic [7:0] _DIGIT_9      = 8'h39;
endpackage

// File: rtl/motor_fb_pkg.sv
// Types and constants for the motor feedback JSON parser.
package motor_fb_pkg;
  typedef enum logic [3:0] {
    IDLE, KEY_OPEN, KEY_CHAR, KEY_CLOSE, COLON, VAL_SIGN,
    VAL_INT, VAL_FRAC, SKIP_VAL, WAIT_LF, DISCARD
  } state_e;

  typedef enum logic [1:0] {KEY_T, KEY_L, KEY_R, KEY_OTHER} key_e;

  localparam logic [7:0] _CARRIAGE_RETURN = 8'h0D;
  localparam logic [7:0] CHR_T = 8'h54;
  localparam logic [7:0] CHR_L = 8'h4C;
  localparam logic [7:0] CHR_R = 8'h52;

  function automatic key_e key_of(input logic [7:0] c);
    case (c)
      CHR_T:   key_of = KEY_T;
      CHR_L:   key_of = KEY_L;
      CHR_R:   key_of = KEY_R;
      default: key_of = KEY_OTHER;
    endcase
  endfunction
endpackage

// File: rtl/ascii_decimal_accum.sv
// Decimal digit accumulator with fraction truncation/padding, overflow
// detection and sign application; value/overflow are combinational views.
module ascii_decimal_accum #(
  parameter int VAL_W       = 16,
  parameter int FRAC_DIGITS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             digit_i,
  input  logic [3:0]       digit_val_i,
  input  logic             point_i,
  input  logic             finish_i,
  input  logic             neg_i,
  input  logic             pad_en_i,
  output logic [VAL_W-1:0] value_o,
  output logic             overflow_o
);
  localparam int ACC_W = VAL_W + 4;
  localparam int FC_W  = $clog2(FRAC_DIGITS + 2);
  localparam logic [ACC_W-1:0] MAX_MAG = ACC_W'((64'd1 << (VAL_W - 1)) - 64'd1);

  logic [ACC_W-1:0] acc_q;
  logic [FC_W-1:0]  frac_q;
  logic             point_q;

  logic [ACC_W-1:0] step_d;
  logic [ACC_W-1:0] padded_d;
  logic [VAL_W-1:0] mag_d;
  logic             frac_full_d;
  logic             pad_ovf_d;

  always_comb begin
    step_d      = acc_q * ACC_W'(10) + ACC_W'(digit_val_i);
    frac_full_d = point_q && (frac_q == FC_W'(FRAC_DIGITS));
    padded_d    = acc_q;
    pad_ovf_d   = 1'b0;
    // Clamp after each *10 so the working width stays bounded.
    for (int i = 0; i < FRAC_DIGITS; i++) begin
      if (pad_en_i && (i >= int'(frac_q))) begin
        padded_d = padded_d * ACC_W'(10);
        if (padded_d > MAX_MAG) begin
          pad_ovf_d = 1'b1;
          padded_d  = MAX_MAG;
        end
      end
    end
    mag_d      = padded_d[VAL_W-1:0];
    value_o    = neg_i ? -mag_d : mag_d;
    overflow_o = (digit_i && !frac_full_d && (step_d > MAX_MAG)) ||
                 (finish_i && pad_ovf_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      frac_q  <= '0;
      point_q <= 1'b0;
    end else if (clear_i) begin
      acc_q   <= '0;
      frac_q  <= '0;
      point_q <= 1'b0;
    end else if (digit_i) begin
      if (!frac_full_d) begin
        acc_q <= step_d;
        if (point_q) frac_q <= frac_q + 1'b1;
      end
    end else if (point_i) begin
      point_q <= 1'b1;
    end
  end
endmodule

// File: rtl/motor_feedback_parser.sv
// Parses {"T":<int>,"L":<dec>,"R":<dec>,...}\n frames from UART RX into fixed-point results.
// Optional type filter: define MOTOR_FB_TYPE_FILTER_EN to drop frames whose T != EXPECT_T.
module motor_feedback_parser
  import ascii_inst_pkg::*;
  import motor_fb_pkg::*;
#(
  parameter int VAL_W       = 16,
  parameter int FRAC_DIGITS = 2,
  parameter int MAX_FRAME   = 64,
  parameter int EXPECT_T    = 1001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             uart_rx_valid,
  input  logic [7:0]       uart_rx_data,
  output logic             uart_rx_ready,
  output logic             fb_valid,
  input  logic             fb_ready,
  output logic [VAL_W-1:0] fb_type,
  output logic [VAL_W-1:0] fb_left,
  output logic [VAL_W-1:0] fb_right,
  output logic             fb_overrun,
  output logic             frame_error
);
`ifdef MOTOR_FB_TYPE_FILTER_EN
  localparam bit TYPE_FILTER = 1'b1;
`else
  localparam bit TYPE_FILTER = 1'b0;
`endif
  localparam int CNT_W = $clog2(MAX_FRAME + 1);

  state_e           state_q;
  key_e             key_q;
  logic             rx_ready_q, neg_q, has_digit_q;
  logic             seen_t_q, seen_l_q, seen_r_q;
  logic [CNT_W-1:0] cnt_q;
  logic [VAL_W-1:0] t_q, l_q, r_q;
  logic [VAL_W-1:0] fb_type_q, fb_left_q, fb_right_q;
  logic             fb_valid_q, fb_overrun_q, frame_error_q;

  logic             take, is_digit, is_term, is_point_ok, byte_bad, type_ok;
  logic             acc_clear, acc_digit, acc_point, acc_finish, acc_ovf;
  logic [VAL_W-1:0] acc_val;
  state_e           err_next_d;

  always_comb begin
    take        = uart_rx_valid && rx_ready_q;
    is_digit    = (uart_rx_data >= _DIGIT_0) && (uart_rx_data <= _DIGIT_9);
    is_term     = (uart_rx_data == _COMMA) || (uart_rx_data == _CLOSE_BRACE);
    is_point_ok = (uart_rx_data == _PERIOD) && (key_q != KEY_T);
    acc_clear   = take && (state_q == COLON);
    acc_digit   = take && is_digit &&
                  ((state_q == VAL_SIGN) || (state_q == VAL_INT) || (state_q == VAL_FRAC));
    acc_point   = take && is_point_ok && ((state_q == VAL_SIGN) || (state_q == VAL_INT));
    acc_finish  = take && is_term && ((state_q == VAL_INT) || (state_q == VAL_FRAC));
    type_ok     = !TYPE_FILTER || (t_q == VAL_W'(EXPECT_T));
    // An error on the '\n' itself already ends the frame, so skip DISCARD.
    err_next_d  = (uart_rx_data == _LINE_FEED) ? IDLE : DISCARD;
    byte_bad    = 1'b0;
    case (state_q)
      KEY_OPEN: byte_bad = (uart_rx_data != _DOUBLE_QUOTE);
      KEY_CHAR: byte_bad = (uart_rx_data == _DOUBLE_QUOTE);
      COLON:    byte_bad = (uart_rx_data != _COLON);
      VAL_SIGN: byte_bad = !((uart_rx_data == _MINUS) || is_digit || is_point_ok) || acc_ovf;
      VAL_INT:  byte_bad = !(is_digit || is_term || is_point_ok) || acc_ovf ||
                           (is_term && !has_digit_q);
      VAL_FRAC: byte_bad = !(is_digit || is_term) || acc_ovf || (is_term && !has_digit_q);
      WAIT_LF:  byte_bad = !((uart_rx_data == _LINE_FEED) ||
                             (uart_rx_data == _CARRIAGE_RETURN));
      default:  byte_bad = 1'b0;
    endcase
    if (cnt_q == CNT_W'(MAX_FRAME)) byte_bad = 1'b1;
  end

  ascii_decimal_accum #(.VAL_W(VAL_W), .FRAC_DIGITS(FRAC_DIGITS)) u_accum (
    .clk        (clk),
    .rst_n      (reset),
    .clear_i    (acc_clear),
    .digit_i    (acc_digit),
    .digit_val_i(uart_rx_data[3:0]),
    .point_i    (acc_point),
    .finish_i   (acc_finish),
    .neg_i      (neg_q),
    .pad_en_i   (key_q != KEY_T),
    .value_o    (acc_val),
    .overflow_o (acc_ovf)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;          key_q <= KEY_OTHER;
      rx_ready_q <= 1'b0;       neg_q <= 1'b0;        has_digit_q <= 1'b0;
      seen_t_q <= 1'b0;         seen_l_q <= 1'b0;     seen_r_q <= 1'b0;
      cnt_q <= '0;              t_q <= '0;            l_q <= '0;      r_q <= '0;
      fb_type_q <= '0;          fb_left_q <= '0;      fb_right_q <= '0;
      fb_valid_q <= 1'b0;       fb_overrun_q <= 1'b0; frame_error_q <= 1'b0;
    end else begin
      rx_ready_q    <= 1'b1;
      frame_error_q <= 1'b0;
      fb_overrun_q  <= 1'b0;
      if (fb_valid_q && fb_ready) fb_valid_q <= 1'b0;
      if (take) begin
        if (uart_rx_data == _OPEN_BRACE) begin
          // A '{' inside a live frame aborts it; inside DISCARD it was already reported.
          frame_error_q <= (state_q != IDLE) && (state_q != DISCARD);
          state_q  <= KEY_OPEN;
          cnt_q    <= CNT_W'(1);
          seen_t_q <= 1'b0;
          seen_l_q <= 1'b0;
          seen_r_q <= 1'b0;
        end else if (state_q == IDLE) begin
          state_q <= IDLE;
        end else if (state_q == DISCARD) begin
          if (uart_rx_data == _LINE_FEED) state_q <= IDLE;
        end else if (byte_bad) begin
          frame_error_q <= 1'b1;
          state_q       <= err_next_d;
        end else begin
          cnt_q <= cnt_q + 1'b1;
          case (state_q)
            KEY_OPEN: state_q <= KEY_CHAR;
            KEY_CHAR: begin
              key_q   <= key_of(uart_rx_data);
              state_q <= KEY_CLOSE;
            end
            KEY_CLOSE: begin
              if (uart_rx_data == _DOUBLE_QUOTE) state_q <= COLON;
              else key_q <= KEY_OTHER;
            end
            COLON: begin
              neg_q       <= 1'b0;
              has_digit_q <= 1'b0;
              state_q     <= (key_q == KEY_OTHER) ? SKIP_VAL : VAL_SIGN;
            end
            VAL_SIGN, VAL_INT, VAL_FRAC: begin
              if (uart_rx_data == _MINUS) begin
                neg_q   <= 1'b1;
                state_q <= VAL_INT;
              end else if (is_digit) begin
                has_digit_q <= 1'b1;
                if (state_q == VAL_SIGN) state_q <= VAL_INT;
              end else if (uart_rx_data == _PERIOD) begin
                state_q <= VAL_FRAC;
              end else begin
                case (key_q)
                  KEY_T:   begin t_q <= acc_val; seen_t_q <= 1'b1; end
                  KEY_L:   begin l_q <= acc_val; seen_l_q <= 1'b1; end
                  KEY_R:   begin r_q <= acc_val; seen_r_q <= 1'b1; end
                  default: ;
                endcase
                state_q <= (uart_rx_data == _COMMA) ? KEY_OPEN : WAIT_LF;
              end
            end
            SKIP_VAL: begin
              if (uart_rx_data == _COMMA) state_q <= KEY_OPEN;
              else if (uart_rx_data == _CLOSE_BRACE) state_q <= WAIT_LF;
            end
            WAIT_LF: begin
              if (uart_rx_data == _LINE_FEED) begin
                state_q <= IDLE;
                if (seen_t_q && seen_l_q && seen_r_q) begin
                  if (type_ok) begin
                    fb_type_q    <= t_q;
                    fb_left_q    <= l_q;
                    fb_right_q   <= r_q;
                    fb_valid_q   <= 1'b1;
                    fb_overrun_q <= fb_valid_q && !fb_ready;
                  end
                end else begin
                  frame_error_q <= 1'b1;
                end
              end
            end
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

  assign uart_rx_ready = rx_ready_q;
  assign fb_valid      = fb_valid_q;
  assign fb_type       = fb_type_q;
  assign fb_left       = fb_left_q;
  assign fb_right      = fb_right_q;
  assign fb_overrun    = fb_overrun_q;
  assign frame_error   = frame_error_q;
endmodule

// File: tb/tb_motor_feedback_parser.sv
// Directed bench for motor_feedback_parser with hand-computed expectations.
module tb_motor_feedback_parser;
  logic        clk = 1'b0;
  logic        reset;
  logic        uart_rx_valid;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_ready;
  logic        fb_valid;
  logic        fb_ready;
  logic [15:0] fb_type, fb_left, fb_right;
  logic        fb_overrun, frame_error;

  int n_chk = 0;
  int n_err = 0;
  int err_pulses = 0;
  int ovr_pulses = 0;
  int e0, o0;

  motor_feedback_parser dut (
    .clk(clk), .reset(reset),
    .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data), .uart_rx_ready(uart_rx_ready),
    .fb_valid(fb_valid), .fb_ready(fb_ready),
    .fb_type(fb_type), .fb_left(fb_left), .fb_right(fb_right),
    .fb_overrun(fb_overrun), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_error) err_pulses++;
    if (fb_overrun) ovr_pulses++;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      uart_rx_valid = 1'b1;
      uart_rx_data  = s[i];
    end
    @(negedge clk);
    uart_rx_valid = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  function automatic int sv(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    string s;
    reset = 1'b0; uart_rx_valid = 1'b0; uart_rx_data = 8'h00; fb_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", uart_rx_ready, 0);
    check("rst_valid", fb_valid, 0);
    check("rst_type", sv(fb_type), 0);
    check("rst_error", frame_error, 0);
    reset = 1'b1;
    settle();
    check("ready_after_rst", uart_rx_ready, 1);

    // basic frame, consumer ready
    fb_ready = 1'b1; e0 = err_pulses;
    send("{\"T\":1001,\"L\":0.05,\"R\":-0.10}\n");
    check("t1_valid", fb_valid, 1);
    check("t1_type", sv(fb_type), 1001);
    check("t1_left", sv(fb_left), 5);
    check("t1_right", sv(fb_right), -10);
    settle();
    check("t1_valid_drop", fb_valid, 0);
    check("t1_err", err_pulses - e0, 0);

    // unknown key skipped, fraction truncated, CR ignored
    e0 = err_pulses;
    send("{\"T\":1001,\"L\":1.5,\"R\":0.123,\"v\":12.02}\r\n");
    check("t2_valid", fb_valid, 1);
    check("t2_left", sv(fb_left), 150);
    check("t2_right", sv(fb_right), 12);
    settle();
    check("t2_err", err_pulses - e0, 0);

    // back-to-back with consumer stalled
    fb_ready = 1'b0; o0 = ovr_pulses;
    send("{\"T\":1001,\"L\":1,\"R\":2}\n");
    check("t3a_valid", fb_valid, 1);
    check("t3a_left", sv(fb_left), 100);
    send("{\"T\":1001,\"L\":-3.25,\"R\":0.5}\n");
    check("t3b_valid", fb_valid, 1);
    check("t3b_left", sv(fb_left), -325);
    check("t3b_right", sv(fb_right), 50);
    settle();
    check("t3_overrun", ovr_pulses - o0, 1);

    // commit on the same edge as a handshake: no overrun
    o0 = ovr_pulses;
    send("{\"T\":1001,\"L\":9,\"R\":9}");
    @(negedge clk);
    uart_rx_valid = 1'b1; uart_rx_data = 8'h0A; fb_ready = 1'b1;
    @(negedge clk);
    uart_rx_valid = 1'b0; fb_ready = 1'b0;
    check("t3c_valid", fb_valid, 1);
    check("t3c_left", sv(fb_left), 900);
    settle();
    check("t3c_overrun", ovr_pulses - o0, 0);
    fb_ready = 1'b1;
    settle();
    check("t3_drop", fb_valid, 0);

    // malformed fraction then good frame
    e0 = err_pulses;
    send("{\"T\":1,\"L\":0.x5,\"R\":0}\n");
    check("t4_bad_valid", fb_valid, 0);
    send("{\"T\":1001,\"L\":3,\"R\":-4}\n");
    check("t4_good_valid", fb_valid, 1);
    check("t4_left", sv(fb_left), 300);
    check("t4_right", sv(fb_right), -400);
    settle();
    check("t4_err", err_pulses - e0, 1);

    // digit overflow
    e0 = err_pulses;
    send("{\"T\":1001,\"L\":400.00,\"R\":0}\n");
    check("t5_valid", fb_valid, 0);
    settle();
    check("t5_err", err_pulses - e0, 1);

    // largest magnitude accepted
    e0 = err_pulses;
    send("{\"T\":1001,\"L\":327.67,\"R\":-327.67}\n");
    check("max_valid", fb_valid, 1);
    check("max_left", sv(fb_left), 32767);
    check("max_right", sv(fb_right), -32767);
    settle();
    check("max_err", err_pulses - e0, 0);

    // overflow only after fraction padding
    e0 = err_pulses;
    send("{\"T\":1001,\"L\":328,\"R\":0}\n");
    check("pad_valid", fb_valid, 0);
    settle();
    check("pad_err", err_pulses - e0, 1);

    // missing R
    e0 = err_pulses;
    send("{\"T\":1001,\"L\":2}\n");
    check("miss_valid", fb_valid, 0);
    settle();
    check("miss_err", err_pulses - e0, 1);

    // '.' in T
    e0 = err_pulses;
    send("{\"T\":10.5,\"L\":1,\"R\":1}\n");
    check("tdot_valid", fb_valid, 0);
    settle();
    check("tdot_err", err_pulses - e0, 1);

    // duplicate key: last wins
    send("{\"T\":1001,\"L\":1,\"L\":2,\"R\":0}\n");
    check("dup_left", sv(fb_left), 200);
    check("dup_right", sv(fb_right), 0);

    // exactly MAX_FRAME bytes commits, one more errors
    e0 = err_pulses;
    s = "{\"T\":1001,\"L\":1,\"R\":1,\"x\":";
    for (int i = 0; i < 36; i++) s = {s, "1"};
    send({s, "}\n"});
    check("len64_valid", fb_valid, 1);
    send({s, "1}\n"});
    check("len65_valid", fb_valid, 0);
    settle();
    check("len_err", err_pulses - e0, 1);

    // reset mid-frame
    fb_ready = 1'b0;
    send("{\"T\":1001,\"L\":7,\"R\":7}\n");
    send("{\"T\":10");
    reset = 1'b0;
    #1;
    check("mid_rst_valid", fb_valid, 0);
    check("mid_rst_left", sv(fb_left), 0);
    check("mid_rst_right", sv(fb_right), 0);
    check("mid_rst_ready", uart_rx_ready, 0);
    @(negedge clk);
    reset = 1'b1; fb_ready = 1'b1; e0 = err_pulses;
    send(",\"L\":1,\"R\":1}\n");
    check("mid_rst_tail_valid", fb_valid, 0);
    settle();
    check("mid_rst_tail_err", err_pulses - e0, 0);

    // type other than EXPECT_T
    e0 = err_pulses;
    send("{\"T\":1,\"L\":0,\"R\":0}\n");
`ifdef MOTOR_FB_TYPE_FILTER_EN
    check("filt_valid", fb_valid, 0);
`else
    check("filt_valid", fb_valid, 1);
    check("filt_type", sv(fb_type), 1);
`endif
    settle();
    check("filt_err", err_pulses - e0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
